// File: rtl/pipe_hazard_seq_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_seq_if
// Bundles the hazard-detect inputs and the pipeline-control outputs of the
// pipe_hazard_seq sequencer. clk and rst are not part of the bundle.
//
//   master : the pipeline datapath side. It drives the hazard/status inputs
//            and receives the enables, flush, PC-select, state and counter.
//   slave  : the hazard sequencer itself.
//
// Signals (master -> slave)
//   load_use     load-use hazard for the instruction in ID
//   br_hd_far    branch/jump operand produced by the instruction in ID/EX
//   br_hd_near   branch/jump operand is a load sitting in EX/MEM
//   ctrl_xfer    ID holds a branch, j, jal or jr
//   redirect     next-PC logic selects a non-sequential target this cycle
//   mem_busy     data memory not ready, the whole pipeline freezes
//   cnt_clr      synchronous clear of stall_cycles
// Signals (slave -> master)
//   pc_we, if_id_we, ex_we   write enables (ex_we covers ID/EX, EX/MEM, MEM/WB)
//   id_ex_bubble             load NOP control into ID/EX
//   if_id_flush              clear IF/ID
//   pc_sel_npc               PC mux selects the computed NPC
//   state                    RUN=0, STALL=1, FREEZE=2
//   stall_cycles             number of cycles with pc_we=0 (saturating)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface pipe_hazard_seq_if;
  logic        load_use;
  logic        br_hd_far;
  logic        br_hd_near;
  logic        ctrl_xfer;
  logic        redirect;
  logic        mem_busy;
  logic        cnt_clr;

  logic        pc_we;
  logic        if_id_we;
  logic        ex_we;
  logic        id_ex_bubble;
  logic        if_id_flush;
  logic        pc_sel_npc;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  modport master (
    output load_use, br_hd_far, br_hd_near, ctrl_xfer, redirect, mem_busy,
           cnt_clr,
    input  pc_we, if_id_we, ex_we, id_ex_bubble, if_id_flush, pc_sel_npc,
           state, stall_cycles
  );

  modport slave (
    input  load_use, br_hd_far, br_hd_near, ctrl_xfer, redirect, mem_busy,
           cnt_clr,
    output pc_we, if_id_we, ex_we, id_ex_bubble, if_id_flush, pc_sel_npc,
           state, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_seq.sv
// -----------------------------------------------------------------------------
// pipe_hazard_seq
// Stall/flush/freeze sequencer for a classic 5-stage pipeline.
//
// Ports
//   clk   single clock, all state changes on the rising edge
//   rst   asynchronous, active-high reset
//   bus   pipe_hazard_seq_if.slave (hazard inputs in, pipeline controls out)
//
// Parameters
//   FAR_STALLS   total stall cycles when a branch/jump operand is produced by
//                the instruction in ID/EX (1..3)
//   NEAR_STALLS  total stall cycles when a branch/jump operand is a load in
//                EX/MEM (1..3)
//
// Behaviour summary
//   RUN    : evaluates hazards in priority order mem_busy, far branch, near
//            branch, load-use, redirect. A branch stall loads the remaining
//            stall count sc and moves to STALL while cycles remain.
//   STALL  : counts sc down, ignoring everything except mem_busy, which holds
//            the countdown in place while the pipe is frozen.
//   FREEZE : everything held while mem_busy is high; on the first cycle with
//            mem_busy low it acts exactly like RUN.
// Outputs are combinational from the state and the inputs and are forced to
// zero while rst is asserted. stall_cycles counts every cycle with pc_we=0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pipe_hazard_seq #(
  parameter int unsigned FAR_STALLS  = 2,
  parameter int unsigned NEAR_STALLS = 1
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_seq_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2,
    ST_BAD    = 2'd3
  } state_t;

  // One bundle for the six combinational controls so each output set below
  // is a single constant.
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic ex_we;
    logic id_ex_bubble;
    logic if_id_flush;
    logic pc_sel_npc;
  } ctl_t;

  localparam ctl_t CTL_NORMAL = ctl_t'(6'b111_000);
  localparam ctl_t CTL_STALL  = ctl_t'(6'b001_100);
  localparam ctl_t CTL_FREEZE = ctl_t'(6'b000_000);
  localparam ctl_t CTL_REDIR  = ctl_t'(6'b111_011);

  // sc holds the stall cycles still to come after the current one, so the
  // cycle that detects the hazard already counts as the first stall.
  localparam logic [1:0] FAR_SC  = 2'(FAR_STALLS - 1);
  localparam logic [1:0] NEAR_SC = 2'(NEAR_STALLS - 1);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // Registers and next-state wires
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic [1:0]  r_sc;
  logic [15:0] r_stall_cycles;

  state_t      w_next_state;
  logic [1:0]  w_next_sc;
  ctl_t        w_ctl;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // races between always blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_sc    <= 2'd0;
    end else begin
      r_state <= w_next_state;
      r_sc    <= w_next_sc;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    w_ctl        = CTL_FREEZE;
    w_next_state = r_state;
    w_next_sc    = r_sc;

    unique case (r_state)
      // FREEZE with mem_busy low is indistinguishable from RUN, so both share
      // the same priority chain.
      ST_RUN, ST_FREEZE: begin
        if (bus.mem_busy) begin
          w_ctl        = CTL_FREEZE;
          w_next_state = ST_FREEZE;
        end else if (bus.ctrl_xfer && bus.br_hd_far) begin
          w_ctl        = CTL_STALL;
          w_next_sc    = FAR_SC;
          w_next_state = (FAR_SC != 2'd0) ? ST_STALL : ST_RUN;
        end else if (bus.ctrl_xfer && bus.br_hd_near) begin
          w_ctl        = CTL_STALL;
          w_next_sc    = NEAR_SC;
          w_next_state = (NEAR_SC != 2'd0) ? ST_STALL : ST_RUN;
        end else if (bus.load_use) begin
          // A load-use bubble is a single cycle and needs no countdown.
          w_ctl        = CTL_STALL;
          w_next_state = ST_RUN;
        end else if (bus.ctrl_xfer && bus.redirect) begin
          w_ctl        = CTL_REDIR;
          w_next_state = ST_RUN;
        end else begin
          w_ctl        = CTL_NORMAL;
          w_next_state = ST_RUN;
        end
      end

      // Only mem_busy is honoured here; the branch is re-evaluated from RUN
      // once the countdown is over.
      ST_STALL: begin
        if (bus.mem_busy) begin
          w_ctl = CTL_FREEZE;
        end else begin
          w_ctl = CTL_STALL;
          // sc==0 cannot occur in STALL; treating it like the last cycle
          // guarantees the countdown always terminates.
          if (r_sc <= 2'd1) begin
            w_next_sc    = 2'd0;
            w_next_state = ST_RUN;
          end else begin
            w_next_sc    = r_sc - 2'd1;
          end
        end
      end

      // Unreachable encoding: recover to RUN with normal flow.
      default: begin
        w_ctl        = CTL_NORMAL;
        w_next_sc    = 2'd0;
        w_next_state = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stall cycle counter
  // ---------------------------------------------------------------------------
  // Clear wins over increment; the count saturates instead of wrapping so a
  // long freeze cannot make the statistic look small.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= 16'd0;
    end else if (bus.cnt_clr) begin
      r_stall_cycles <= 16'd0;
    end else if (!w_ctl.pc_we && (r_stall_cycles != CNT_MAX)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Reset is asynchronous, so the combinational controls are gated with rst
  // directly; otherwise they would follow the live inputs during reset.
  assign bus.pc_we        = !rst && w_ctl.pc_we;
  assign bus.if_id_we     = !rst && w_ctl.if_id_we;
  assign bus.ex_we        = !rst && w_ctl.ex_we;
  assign bus.id_ex_bubble = !rst && w_ctl.id_ex_bubble;
  assign bus.if_id_flush  = !rst && w_ctl.if_id_flush;
  assign bus.pc_sel_npc   = !rst && w_ctl.pc_sel_npc;
  assign bus.state        = r_state;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_seq.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_seq
// Self-checking bench for pipe_hazard_seq with default parameters.
// Inputs change on the falling edge; outputs are sampled 1ns later, well away
// from the rising edge. Directed scenarios use expected-value tables; the
// random scenario uses a small behavioural model that tracks "stall cycles
// still owed" and "pipe frozen" rather than a state machine.
// Stimulus word layout: {rst, load_use, far, near, ctrl_xfer, redirect,
// mem_busy, cnt_clr}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pipe_hazard_seq;

  localparam int FAR  = 2;
  localparam int NEAR = 1;

  // Expected control vectors {pc_we, if_id_we, ex_we, bubble, flush, sel}
  localparam logic [5:0] C_NORM = 6'b111000;
  localparam logic [5:0] C_STL  = 6'b001100;
  localparam logic [5:0] C_FRZ  = 6'b000000;
  localparam logic [5:0] C_RDR  = 6'b111011;

  // Common stimulus words
  localparam logic [7:0] S_IDLE  = 8'b0000_0000;
  localparam logic [7:0] S_CLR   = 8'b0000_0001;
  localparam logic [7:0] S_LU    = 8'b0100_0000;
  localparam logic [7:0] S_CXFAR = 8'b0010_1000;
  localparam logic [7:0] S_CXRD  = 8'b0000_1100;
  localparam logic [7:0] S_BUSY  = 8'b0000_0010;
  localparam logic [7:0] S_RST   = 8'b1000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_seq_if bus ();

  pipe_hazard_seq #(
    .FAR_STALLS  (FAR),
    .NEAR_STALLS (NEAR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wire [5:0] got_ctl = {bus.pc_we, bus.if_id_we, bus.ex_we,
                        bus.id_ex_bubble, bus.if_id_flush, bus.pc_sel_npc};

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int          m_owed;    // branch stall cycles still to come after this one
  bit          m_frozen;  // last cycle froze the pipe from RUN
  int unsigned m_cnt;
  logic [5:0]  m_ctl;
  logic [1:0]  m_st;

  // Apply one stimulus word on the falling edge, then settle.
  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    rst             = v[7];
    bus.load_use    = v[6];
    bus.br_hd_far   = v[5];
    bus.br_hd_near  = v[4];
    bus.ctrl_xfer   = v[3];
    bus.redirect    = v[2];
    bus.mem_busy    = v[1];
    bus.cnt_clr     = v[0];
    #1;
  endtask

  // Expected outputs for the current cycle, straight from the priority rules.
  task automatic model_eval(input logic [7:0] v);
    bit r, lu, far, near, cx, rd, busy;
    {r, lu, far, near, cx, rd, busy} = v[7:1];
    if (r) begin
      m_owed = 0; m_frozen = 0; m_cnt = 0; m_ctl = C_FRZ; m_st = 2'd0;
      return;
    end
    if (m_owed > 0) begin
      m_st  = 2'd1;
      m_ctl = busy ? C_FRZ : C_STL;
    end else begin
      m_st = m_frozen ? 2'd2 : 2'd0;
      if (busy)                           m_ctl = C_FRZ;
      else if (cx && (far || near) || lu) m_ctl = C_STL;
      else if (cx && rd)                  m_ctl = C_RDR;
      else                                m_ctl = C_NORM;
    end
  endtask

  // Advance the model across the rising edge.
  task automatic model_step(input logic [7:0] v);
    bit r, lu, far, near, cx, rd, busy, clr;
    {r, lu, far, near, cx, rd, busy, clr} = v;
    if (r) return;
    if (clr)                                m_cnt = 0;
    else if (!m_ctl[5] && m_cnt < 32'hFFFF) m_cnt = m_cnt + 1;
    if (m_owed > 0) begin
      if (!busy) m_owed = m_owed - 1;
    end else if (busy) begin
      m_frozen = 1;
    end else begin
      m_frozen = 0;
      if (cx && far)       m_owed = FAR - 1;
      else if (cx && near) m_owed = NEAR - 1;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive({1'b1, 7'($urandom)});
      checks++;
      if ({got_ctl, bus.state, bus.stall_cycles} !== {C_FRZ, 2'd0, 16'd0}) begin
        failures++;
        $display("FAIL reset step %0d: ctl=%b state=%0d cnt=%0h, expected ctl=000000 state=0 cnt=0",
                 i, got_ctl, bus.state, bus.stall_cycles);
      end
    end
    drive(S_IDLE);
    checks++;
    if ({got_ctl, bus.state} !== {C_NORM, 2'd0}) begin
      failures++;
      $display("FAIL reset_release: ctl=%b state=%0d, expected ctl=%b state=0",
               got_ctl, bus.state, C_NORM);
    end
  endtask

  task automatic test_load_use();
    logic [7:0]  st [3] = '{S_LU, S_IDLE, S_IDLE};
    logic [5:0]  ec [3] = '{C_STL, C_NORM, C_NORM};
    logic [1:0]  es [3] = '{2'd0, 2'd0, 2'd0};
    logic [15:0] en [3] = '{16'd0, 16'd1, 16'd1};
    drive(S_CLR);
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      checks++;
      if ({got_ctl, bus.state, bus.stall_cycles} !== {ec[i], es[i], en[i]}) begin
        failures++;
        $display("FAIL load_use step %0d: ctl=%b state=%0d cnt=%0d, expected ctl=%b state=%0d cnt=%0d",
                 i, got_ctl, bus.state, bus.stall_cycles, ec[i], es[i], en[i]);
      end
    end
  endtask

  task automatic test_far_branch();
    logic [7:0]  st [4] = '{S_CXFAR, S_CXFAR, S_CXRD, S_IDLE};
    logic [5:0]  ec [4] = '{C_STL, C_STL, C_RDR, C_NORM};
    logic [1:0]  es [4] = '{2'd0, 2'd1, 2'd0, 2'd0};
    logic [15:0] en [4] = '{16'd0, 16'd1, 16'd2, 16'd2};
    drive(S_CLR);
    for (int i = 0; i < 4; i++) begin
      drive(st[i]);
      checks++;
      if ({got_ctl, bus.state, bus.stall_cycles} !== {ec[i], es[i], en[i]}) begin
        failures++;
        $display("FAIL far_branch step %0d: ctl=%b state=%0d cnt=%0d, expected ctl=%b state=%0d cnt=%0d",
                 i, got_ctl, bus.state, bus.stall_cycles, ec[i], es[i], en[i]);
      end
    end
  endtask

  task automatic test_near_load();
    logic [7:0]  st [3] = '{8'b0101_1000, S_IDLE, S_IDLE};
    logic [5:0]  ec [3] = '{C_STL, C_NORM, C_NORM};
    logic [1:0]  es [3] = '{2'd0, 2'd0, 2'd0};
    logic [15:0] en [3] = '{16'd0, 16'd1, 16'd1};
    drive(S_CLR);
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      checks++;
      if ({got_ctl, bus.state, bus.stall_cycles} !== {ec[i], es[i], en[i]}) begin
        failures++;
        $display("FAIL near_load step %0d: ctl=%b state=%0d cnt=%0d, expected ctl=%b state=%0d cnt=%0d",
                 i, got_ctl, bus.state, bus.stall_cycles, ec[i], es[i], en[i]);
      end
    end
  endtask

  // Inputs other than mem_busy must not disturb the countdown.
  task automatic test_stall_ignores();
    logic [7:0]  st [3] = '{S_CXFAR, 8'b0101_1100, S_IDLE};
    logic [5:0]  ec [3] = '{C_STL, C_STL, C_NORM};
    logic [1:0]  es [3] = '{2'd0, 2'd1, 2'd0};
    logic [15:0] en [3] = '{16'd0, 16'd1, 16'd2};
    drive(S_CLR);
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      checks++;
      if ({got_ctl, bus.state, bus.stall_cycles} !== {ec[i], es[i], en[i]}) begin
        failures++;
        $display("FAIL stall_ignores step %0d: ctl=%b state=%0d cnt=%0d, expected ctl=%b state=%0d cnt=%0d",
                 i, got_ctl, bus.state, bus.stall_cycles, ec[i], es[i], en[i]);
      end
    end
  endtask

  task automatic test_freeze_in_stall();
    logic [7:0]  st [6] = '{S_CXFAR, S_BUSY, S_BUSY, S_BUSY, S_IDLE, S_IDLE};
    logic [5:0]  ec [6] = '{C_STL, C_FRZ, C_FRZ, C_FRZ, C_STL, C_NORM};
    logic [1:0]  es [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    logic [15:0] en [6] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    drive(S_CLR);
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      checks++;
      if ({got_ctl, bus.state, bus.stall_cycles} !== {ec[i], es[i], en[i]}) begin
        failures++;
        $display("FAIL freeze_in_stall step %0d: ctl=%b state=%0d cnt=%0d, expected ctl=%b state=%0d cnt=%0d",
                 i, got_ctl, bus.state, bus.stall_cycles, ec[i], es[i], en[i]);
      end
    end
  endtask

  // Leaving FREEZE straight into a far branch uses the RUN rules.
  task automatic test_freeze_run();
    logic [7:0]  st [5] = '{S_BUSY, S_BUSY, S_CXFAR, S_IDLE, S_IDLE};
    logic [5:0]  ec [5] = '{C_FRZ, C_FRZ, C_STL, C_STL, C_NORM};
    logic [1:0]  es [5] = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd0};
    logic [15:0] en [5] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4};
    drive(S_CLR);
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      checks++;
      if ({got_ctl, bus.state, bus.stall_cycles} !== {ec[i], es[i], en[i]}) begin
        failures++;
        $display("FAIL freeze_run step %0d: ctl=%b state=%0d cnt=%0d, expected ctl=%b state=%0d cnt=%0d",
                 i, got_ctl, bus.state, bus.stall_cycles, ec[i], es[i], en[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  st [8] = '{S_CXFAR, 8'b1010_1010, S_RST, S_IDLE,
                            S_BUSY, S_BUSY, 8'b1000_0010, S_IDLE};
    logic [5:0]  ec [8] = '{C_STL, C_FRZ, C_FRZ, C_NORM,
                            C_FRZ, C_FRZ, C_FRZ, C_NORM};
    logic [1:0]  es [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
    logic [15:0] en [8] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0};
    drive(S_CLR);
    for (int i = 0; i < 8; i++) begin
      drive(st[i]);
      checks++;
      if ({got_ctl, bus.state, bus.stall_cycles} !== {ec[i], es[i], en[i]}) begin
        failures++;
        $display("FAIL reset_mid step %0d: ctl=%b state=%0d cnt=%0d, expected ctl=%b state=%0d cnt=%0d",
                 i, got_ctl, bus.state, bus.stall_cycles, ec[i], es[i], en[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0]  st [6] = '{S_IDLE, S_LU, S_LU, S_LU, 8'b0100_0001, S_IDLE};
    logic [5:0]  ec [6] = '{C_NORM, C_STL, C_STL, C_STL, C_STL, C_NORM};
    logic [1:0]  es [6] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [15:0] en [6] = '{16'hFFFE, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
    drive(S_CLR);
    drive(S_BUSY);
    repeat (65534) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      checks++;
      if ({got_ctl, bus.state, bus.stall_cycles} !== {ec[i], es[i], en[i]}) begin
        failures++;
        $display("FAIL saturation step %0d: ctl=%b state=%0d cnt=%0h, expected ctl=%b state=%0d cnt=%0h",
                 i, got_ctl, bus.state, bus.stall_cycles, ec[i], es[i], en[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    int shown = 0;
    drive(S_RST);
    model_eval(S_RST);
    model_step(S_RST);
    for (int i = 0; i < 3000; i++) begin
      v[7] = ($urandom_range(0, 59) == 0);
      v[6] = ($urandom_range(0, 3) == 0);
      v[5] = ($urandom_range(0, 3) == 0);
      v[4] = ($urandom_range(0, 3) == 0);
      v[3] = ($urandom_range(0, 1) == 0);
      v[2] = ($urandom_range(0, 1) == 0);
      v[1] = ($urandom_range(0, 4) == 0);
      v[0] = ($urandom_range(0, 15) == 0);
      drive(v);
      model_eval(v);
      checks++;
      if ({got_ctl, bus.state, bus.stall_cycles} !== {m_ctl, m_st, 16'(m_cnt)}) begin
        failures++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random cycle %0d in=%b: ctl=%b state=%0d cnt=%0d, expected ctl=%b state=%0d cnt=%0d",
                   i, v, got_ctl, bus.state, bus.stall_cycles, m_ctl, m_st, m_cnt);
        end
      end
      model_step(v);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst            = 1'b1;
    bus.load_use   = 1'b0;
    bus.br_hd_far  = 1'b0;
    bus.br_hd_near = 1'b0;
    bus.ctrl_xfer  = 1'b0;
    bus.redirect   = 1'b0;
    bus.mem_busy   = 1'b0;
    bus.cnt_clr    = 1'b0;

    test_reset();
    test_load_use();
    test_far_branch();
    test_near_load();
    test_stall_ignores();
    test_freeze_in_stall();
    test_freeze_run();
    test_reset_mid();
    test_saturation();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_seq.md
PIPE_HAZARD_SEQ -- requirements
Module: pipe_hazard_seq

Interface
REQ-001 Parameter FAR_STALLS, default 2: total stall cycles for a branch/jump whose operand producer sits in ID/EX; legal range 1..3.
REQ-002 Parameter NEAR_STALLS, default 1: total stall cycles for a branch/jump whose operand is a load in EX/MEM; legal range 1..3.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 load_use  input  1  load-use hazard detected for the instruction in ID.
REQ-006 br_hd_far  input  1  branch/jump operand produced by the instruction in ID/EX.
REQ-007 br_hd_near  input  1  branch/jump operand is a load in EX/MEM.
REQ-008 ctrl_xfer  input  1  ID holds a branch, j, jal or jr.
REQ-009 redirect  input  1  next-PC logic selects a non-sequential target this cycle.
REQ-010 mem_busy  input  1  data memory not ready; whole pipeline must freeze.
REQ-011 cnt_clr  input  1  synchronous clear of stall_cycles.
REQ-012 pc_we, if_id_we, ex_we  output  1 each  write enables for PC, IF/ID, and the ID/EX, EX/MEM, MEM/WB registers.
REQ-013 id_ex_bubble  output  1  load NOP control into ID/EX.
REQ-014 if_id_flush  output  1  clear IF/ID.
REQ-015 pc_sel_npc  output  1  PC mux selects the computed NPC.
REQ-016 state  output  2  current state: RUN=0, STALL=1, FREEZE=2; 3 unused.
REQ-017 stall_cycles  output  16  count of cycles with pc_we=0.

Function
REQ-018 State, the 2-bit stall counter sc, and stall_cycles SHALL be registered; all enable/flush outputs SHALL be combinational from state and inputs.
REQ-019 Output sets: NORMAL = pc_we, if_id_we, ex_we = 1, all others 0; STALLSET = pc_we=0, if_id_we=0, id_ex_bubble=1, ex_we=1; FREEZESET = all enables 0, bubble 0, flush 0; REDIR = NORMAL plus pc_sel_npc=1, if_id_flush=1.
REQ-020 RUN, priority high to low: mem_busy -> FREEZESET, next FREEZE; ctrl_xfer&br_hd_far -> STALLSET, sc<=FAR_STALLS-1; ctrl_xfer&br_hd_near -> STALLSET, sc<=NEAR_STALLS-1; load_use -> STALLSET, stay RUN; ctrl_xfer&redirect -> REDIR; else NORMAL.
REQ-021 On a branch stall from RUN, next state SHALL be STALL if the loaded sc is nonzero, else RUN; total stall cycles therefore equal the parameter.
REQ-022 STALL: mem_busy -> FREEZESET, sc and state held; else STALLSET, and if sc==1 then sc<=0 and next RUN, otherwise sc<=sc-1.
REQ-023 In STALL, redirect, load_use and the hazard inputs SHALL be ignored; the first RUN cycle after STALL re-evaluates all inputs.
REQ-024 FREEZE: FREEZESET while mem_busy=1; when mem_busy=0, behave as RUN for that cycle with the REQ-020 priorities and next-state rules.
REQ-025 stall_cycles SHALL increment by 1 on each cycle with pc_we=0, saturate at 16'hFFFF, and clear to 0 when cnt_clr=1; clear has priority over increment.
REQ-026 State encoding 3 SHALL be unreachable; if ever entered, next state RUN with NORMAL outputs.

Reset
REQ-027 While rst=1, state=RUN, sc=0, stall_cycles=0, and all enable/flush/select outputs SHALL be 0 regardless of other inputs.
REQ-028 Reset asserted mid-STALL or mid-FREEZE SHALL abort the sequence immediately; after release, the first edge evaluates from RUN.

Verification
REQ-029 Input load_use=1 for 1 cycle in RUN -> exactly 1 cycle of STALLSET, state stays 0, stall_cycles=1.
REQ-030 Input ctrl_xfer=1 and br_hd_far=1, defaults -> 2 consecutive STALLSET cycles, state 0->1->0, then redirect=1 in the resolve cycle gives pc_sel_npc=1 and if_id_flush=1.
REQ-031 Input ctrl_xfer, br_hd_near and load_use all asserted together -> 1 stall cycle only, no STALL state entry.
REQ-032 Input mem_busy=1 for 3 cycles during the STALL state of a far branch -> 3 FREEZESET cycles with sc held, then 1 remaining STALLSET cycle, stall_cycles=5.
REQ-033 Input rst pulse during STALL -> outputs 0 while rst=1, state=0; after release with idle inputs, NORMAL outputs.
REQ-034 Preload stall_cycles to 16'hFFFE via 3 extra stall cycles -> count holds at 16'hFFFF; cnt_clr=1 together with a stall cycle -> 0.
